// File: rtl/div16_seq.sv
// Sequential 16-bit unsigned restoring divider: one quotient bit per cycle, MSB first.
// A zero divisor skips the iteration and reports saturated quotient with o_div_zero.
//
// state | meaning
// IDLE  | waiting for i_start
// RUN   | 16 restoring-division steps in progress (o_busy)
// DONE  | results valid for one cycle (o_done); accepts back-to-back start
module div16_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [0:15] i_dividend,
  input  logic [0:15] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [0:15] o_quotient,
  output logic [0:15] o_remainder,
  output logic        o_div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic [3:0]  cnt_q;
  logic [15:0] dvd_q, dvs_q, rem_q, quo_q;
  logic [16:0] shifted, diff;
  logic        keep;
  logic [15:0] rem_d, quo_d;
  logic        last_step;

  // rem_q < dvs_q, so a kept difference always fits in 16 bits and bit 16 is the borrow
  assign shifted   = {rem_q, dvd_q[15]};
  assign diff      = shifted - {1'b0, dvs_q};
  assign keep      = ~diff[16];
  assign rem_d     = keep ? diff[15:0] : shifted[15:0];
  assign quo_d     = {quo_q[14:0], keep};
  assign last_step = (cnt_q == 4'd15);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          accept  = 1'b1;
          state_d = (i_divisor == 16'd0) ? DONE : RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last_step) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy = (state_q == RUN);
  assign o_done = (state_q == DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      dvd_q       <= 16'd0;
      dvs_q       <= 16'd0;
      rem_q       <= 16'd0;
      quo_q       <= 16'd0;
      o_quotient  <= 16'd0;
      o_remainder <= 16'd0;
      o_div_zero  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dvd_q      <= i_dividend;
        dvs_q      <= i_divisor;
        rem_q      <= 16'd0;
        quo_q      <= 16'd0;
        cnt_q      <= 4'd0;
        o_div_zero <= 1'b0;
        if (i_divisor == 16'd0) begin
          o_quotient  <= 16'hFFFF;
          o_remainder <= i_dividend;
          o_div_zero  <= 1'b1;
        end
      end else if (state_q == RUN) begin
        dvd_q <= {dvd_q[14:0], 1'b0};
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q + 4'd1;
        if (last_step) begin
          o_quotient  <= quo_d;
          o_remainder <= rem_d;
        end
      end
    end
  end

endmodule
